mmu: RTL and testbench

// - 4x4 weight-stationary systolic matrix-multiply unit; core compute block of the TPU datapath.
// - Phase 1 (control=1): preload a 4x4 grid of 8-bit weights, one row per cycle.
// - Phase 2 (control=0): stream pre-skewed 8-bit activation vectors in from the left.

---
 rtl/mmu_pkg.sv | 18 +
 rtl/mmu_pe.sv | 41 ++++
 rtl/mmu.sv | 65 ++++++
 tb/tb_mmu.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared widths and types for the 4x4 weight-stationary systolic multiply unit.
package mmu_pkg;

   localparam int N      = 4;
   localparam int DATA_W = 8;
   localparam int ACC_W  = 32;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ACC_W-1:0]  acc_t;

   // One PE's multiply-accumulate: unsigned 8x8 product, zero-extended, sum wraps mod 2^32.
   function automatic acc_t pe_mac(input acc_t p_in, input data_t w, input data_t a);
      acc_t prod;
      prod = acc_t'(w) * acc_t'(a);
      return p_in + prod;
   endfunction

endpackage

// File: rtl/mmu_pe.sv
// Single processing element: stationary weight, activation pass-through register,
// and partial-sum register. Load mode shifts weights and flushes the pipeline.
module mmu_pe
   import mmu_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  load,
   input  data_t w_in,
   input  data_t a_in,
   input  acc_t  p_in,
   output data_t w,
   output data_t a_reg,
   output acc_t  p_reg
);

   // Weight shift on load, hold during compute; reset wins over load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w <= '0;
      end else if (load) begin
         w <= w_in;
      end
   end

   // Activation and partial-sum pipeline; cleared on every load edge so a mode
   // switch mid-stream discards any in-flight sums.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_reg <= '0;
         p_reg <= '0;
      end else if (load) begin
         a_reg <= '0;
         p_reg <= '0;
      end else begin
         a_reg <= a_in;
         p_reg <= pe_mac(p_in, w, a_in);
      end
   end

endmodule

// File: rtl/mmu.sv
// 4x4 weight-stationary systolic matrix-multiply unit. Weights enter from the top
// one row per load edge; activations enter from the left pre-skewed by row; column
// sums leave the bottom row already registered.
module mmu
   import mmu_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           control,
   input  logic [31:0]    data_arr,
   input  logic [31:0]    wt_arr,
   output logic [127:0]   acc_out
);

   data_t w_grid [N][N];
   data_t a_grid [N][N];
   acc_t  p_grid [N][N];

   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
         data_t w_in;
         data_t a_in;
         acc_t  p_in;

         // Weights enter row 0 from wt_arr and ripple downward on each load edge.
         if (r == 0) begin : g_w_top
            assign w_in = wt_arr[DATA_W*c +: DATA_W];
         end else begin : g_w_chain
            assign w_in = w_grid[r-1][c];
         end

         // Activations enter column 0 from data_arr and move right one PE per edge.
         if (c == 0) begin : g_a_left
            assign a_in = data_arr[DATA_W*r +: DATA_W];
         end else begin : g_a_chain
            assign a_in = a_grid[r][c-1];
         end

         // Partial sums start at zero in row 0 and accumulate downward.
         if (r == 0) begin : g_p_top
            assign p_in = '0;
         end else begin : g_p_chain
            assign p_in = p_grid[r-1][c];
         end

         mmu_pe u_pe (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (control),
            .w_in  (w_in),
            .a_in  (a_in),
            .p_in  (p_in),
            .w     (w_grid[r][c]),
            .a_reg (a_grid[r][c]),
            .p_reg (p_grid[r][c])
         );
      end
   end

   // Bottom-row partial sums are the column results; no extra register stage.
   for (genvar c = 0; c < N; c++) begin : g_out
      assign acc_out[ACC_W*c +: ACC_W] = p_grid[N-1][c];
   end

endmodule

// File: tb/tb_mmu.sv
// Self-checking bench for mmu: table-driven load/compute vectors plus
// hand-written streaming, abort and reset sequences.
module tb_mmu;

   logic         clk;
   logic         rst_n;
   logic         control;
   logic [31:0]  data_arr;
   logic [31:0]  wt_arr;
   logic [127:0] acc_out;

   int checks;
   int failures;

   logic [127:0] res [10];

   typedef struct packed {
      logic [127:0] wts;   // word i (bits 32i+:32) is the i-th word presented
      logic [31:0]  xs;    // byte r = x[r]
      logic [127:0] exp;   // word c = expected column c
   } vec_t;

   vec_t vecs [4];

   mmu dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .control  (control),
      .data_arr (data_arr),
      .wt_arr   (wt_arr),
      .acc_out  (acc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic ctrl, input logic [31:0] d, input logic [31:0] wt);
      control  = ctrl;
      data_arr = d;
      wt_arr   = wt;
      @(posedge clk);
      #1;
   endtask

   task automatic load4(input logic [127:0] wts);
      for (int i = 0; i < 4; i++) step(1'b1, 32'h0, wts[32*i +: 32]);
   endtask

   // Skewed vector x1 starting at cycle 0, optional x2 starting at cycle 1.
   task automatic run_vec(input logic [31:0] x1, input logic [31:0] x2);
      logic [31:0] d;
      for (int k = 0; k < 10; k++) begin
         d = 32'h0;
         for (int r = 0; r < 4; r++) begin
            if (k == r)          d[8*r +: 8] = x1[8*r +: 8];
            else if (k == r + 1) d[8*r +: 8] = x2[8*r +: 8];
         end
         step(1'b0, d, 32'h0);
         res[k] = acc_out;
      end
   endtask

   function automatic logic [127:0] rep4(input logic [31:0] v);
      return {v, v, v, v};
   endfunction

   initial begin
      logic [127:0] outside;
      logic [127:0] got_col;
      logic [127:0] exp_col;

      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      control  = 1'b0;
      data_arr = 32'h0;
      wt_arr   = 32'h0;

      vecs[0] = '{wts: rep4(32'h01010101), xs: 32'h04030201, exp: rep4(32'd10)};
      vecs[1] = '{wts: {32'h0, 32'h0, 32'h0, 32'h00000001}, xs: 32'h05030201,
                  exp: {32'd0, 32'd0, 32'd0, 32'd5}};
      vecs[2] = '{wts: {32'h05020304, 32'h03010203, 32'h07040102, 32'h01020403},
                  xs: 32'h02010201, exp: {32'd20, 32'd12, 32'd16, 32'd18}};
      vecs[3] = '{wts: rep4(32'hFFFFFFFF), xs: 32'hFFFFFFFF, exp: rep4(32'h0003F804)};

      step(1'b0, 32'h0, 32'h0);
      step(1'b0, 32'h0, 32'h0);
      check("reset_initial", acc_out, 128'h0);
      rst_n = 1'b1;

      for (int v = 0; v < 4; v++) begin
         load4(vecs[v].wts);
         run_vec(vecs[v].xs, 32'h0);
         outside = 128'h0;
         for (int c = 0; c < 4; c++) begin
            got_col = {96'h0, res[3+c][32*c +: 32]};
            exp_col = {96'h0, vecs[v].exp[32*c +: 32]};
            check($sformatf("vec%0d_col%0d", v, c), got_col, exp_col);
         end
         for (int k = 0; k < 10; k++)
            for (int c = 0; c < 4; c++)
               if (k != 3 + c) outside[32*c +: 32] = outside[32*c +: 32] | res[k][32*c +: 32];
         check($sformatf("vec%0d_zero_outside", v), outside, 128'h0);
      end

      // Max weights still loaded: max vector followed back-to-back by zeros.
      run_vec(32'hFFFFFFFF, 32'h0);
      for (int c = 0; c < 4; c++) begin
         check($sformatf("b2b_max_col%0d", c), {96'h0, res[3+c][32*c +: 32]}, {96'h0, 32'h0003F804});
         check($sformatf("b2b_zero_col%0d", c), {96'h0, res[4+c][32*c +: 32]}, 128'h0);
      end

      // Streaming with two nonzero vectors on consecutive cycles.
      load4(rep4(32'h01010101));
      run_vec(32'h04030201, 32'h08070605);
      for (int c = 0; c < 4; c++) begin
         check($sformatf("stream_v1_col%0d", c), {96'h0, res[3+c][32*c +: 32]}, {96'h0, 32'd10});
         check($sformatf("stream_v2_col%0d", c), {96'h0, res[4+c][32*c +: 32]}, {96'h0, 32'd26});
      end

      // Abort: raise control mid-stream; sums must flush and new weights take effect.
      step(1'b0, 32'h00000001, 32'h0);
      step(1'b0, 32'h00000200, 32'h0);
      step(1'b0, 32'h00030000, 32'h0);
      step(1'b1, 32'h04000000, 32'h02020202);
      check("abort_flush", acc_out, 128'h0);
      for (int i = 0; i < 3; i++) step(1'b1, 32'h0, 32'h02020202);
      run_vec(32'h01010101, 32'h0);
      for (int c = 0; c < 4; c++)
         check($sformatf("abort_reload_col%0d", c), {96'h0, res[3+c][32*c +: 32]}, {96'h0, 32'd8});

      // Reset after random traffic, with control high to confirm reset priority.
      for (int i = 0; i < 8; i++)
         step(1'($urandom_range(1, 0)), 32'($urandom), 32'($urandom));
      rst_n = 1'b0;
      step(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      check("reset_acc", acc_out, 128'h0);
      rst_n = 1'b1;
      run_vec(32'hFFFFFFFF, 32'hFFFFFFFF);
      outside = 128'h0;
      for (int k = 0; k < 10; k++) outside = outside | res[k];
      check("reset_weights_zero", outside, 128'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
